// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame defaults and the
// baud-tick divisor calculation common to the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DEF_N_SAMPLES = 16;
    localparam int unsigned DEF_NB_BYTE   = 8;

    // Truncating divisor; never returns 0 so the tick counter stays legal.
    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate,
                                             input int unsigned n_samples);
        int unsigned div;
        div = clk_freq / (baud_rate * n_samples);
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversampling tick generator: one-cycle tick every DIV clocks,
// restartable with i_clear so frame timing is relative to the clear edge.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 5000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD_RATE, N_SAMPLES);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign o_tick = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (i_clear || o_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tx_baudrate.sv
// UART transmitter: one NB_DATA-bit word per handshake, sent as back-to-back
// 8N1 frames low byte first, with a registered idle-high serial line.
module tx_baudrate
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA   = 16,
    parameter int unsigned NB_BYTE   = DEF_NB_BYTE,
    parameter int unsigned CLK_FREQ  = 5000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned N_SAMPLES = DEF_N_SAMPLES
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_data,
    output logic               o_done
);

    localparam int unsigned N_BYTES = NB_DATA / NB_BYTE;
    localparam int unsigned SMP_W   = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int unsigned BIT_W   = (NB_BYTE > 1) ? $clog2(NB_BYTE) : 1;
    localparam int unsigned IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    tx_state_e          state_q, state_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NB_DATA-1:0] sh_q, sh_d;
    logic               line_q, line_d;
    logic               tick, accept, bit_end;

    assign o_ready = (state_q == IDLE);
    assign accept  = i_valid && o_ready;
    assign bit_end = tick && (smp_q == SMP_W'(N_SAMPLES - 1));
    assign o_data  = line_q;

    baud_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .N_SAMPLES (N_SAMPLES)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (accept),
        .o_tick  (tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            smp_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            smp_q   <= smp_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        line_d  = line_q;
        o_done  = 1'b0;

        // Sample counter restarts with the divider on acceptance.
        if (accept) begin
            smp_d = '0;
        end else if (tick) begin
            smp_d = bit_end ? '0 : smp_q + 1'b1;
        end else begin
            smp_d = smp_q;
        end

        unique case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (accept) begin
                    sh_d    = i_data;
                    idx_d   = '0;
                    bit_d   = '0;
                    line_d  = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    line_d  = sh_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_d = sh_q >> 1;
                    if (bit_q == BIT_W'(NB_BYTE - 1)) begin
                        line_d  = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        line_d = sh_q[1];
                    end
                end
            end
            STOP: begin
                line_d = 1'b1;
                if (bit_end) begin
                    if (idx_q != IDX_W'(N_BYTES - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        line_d  = 1'b0;
                        state_d = START;
                    end else begin
                        o_done  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                line_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_baudrate.sv
// Bench for tx_baudrate: table-driven words plus random words, each line
// waveform compared cycle by cycle against a frame model and mid-bit decoded.
module tb_tx_baudrate;

    localparam int BC0 = 512;
    localparam int W0  = 20 * BC0;
    localparam int BC1 = 16;
    localparam int W1  = 20 * BC1;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] data;
    bit          sel;
    logic        ready0, line0, done0;
    logic        ready1, line1, done1;
    logic        cur_ready, cur_line, cur_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tx_baudrate u_dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (data),
        .i_valid (valid & ~sel),
        .o_ready (ready0),
        .o_data  (line0),
        .o_done  (done0)
    );

    tx_baudrate #(
        .CLK_FREQ  (1600000),
        .BAUD_RATE (100000)
    ) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_data  (data),
        .i_valid (valid & sel),
        .o_ready (ready1),
        .o_data  (line1),
        .o_done  (done1)
    );

    assign cur_ready = sel ? ready1 : ready0;
    assign cur_line  = sel ? line1  : line0;
    assign cur_done  = sel ? done1  : done0;

    typedef struct {
        logic [15:0] word;
        int          hold;
        logic [15:0] hold_data;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_word(input logic [15:0] w);
        @(negedge clk);
        valid = 1'b1;
        data  = w;
        check("ready_before_accept", {31'd0, cur_ready}, 32'd1);
    endtask

    // Called just after the acceptance edge; k counts cycles after it.
    task automatic run_word(input logic [15:0] w, input int bc, input int hold,
                            input logic [15:0] hold_data, input logic [15:0] exp_word);
        int          nclk;
        int          mism;
        int          first_bad;
        int          done_cnt;
        int          done_at;
        int          ready_hi;
        int          ns;
        int          bi;
        int          fi;
        logic        exp_bit;
        logic [19:0] samp;
        logic [15:0] rx;
        logic        framing_ok;
        nclk = 20 * bc;
        mism = 0; first_bad = -1; done_cnt = 0; done_at = -1; ready_hi = 0; ns = 0;
        samp = '0;
        for (int k = 1; k <= nclk + 1; k++) begin
            @(negedge clk);
            if (k <= hold) begin
                valid = 1'b1;
                data  = hold_data;
            end else begin
                valid = 1'b0;
            end
            if (k <= nclk) begin
                bi = (k - 1) / bc;
                fi = bi % 10;
                if (fi == 0)      exp_bit = 1'b0;
                else if (fi == 9) exp_bit = 1'b1;
                else              exp_bit = w[(bi / 10) * 8 + fi - 1];
                if (cur_line !== exp_bit) begin
                    mism++;
                    if (first_bad < 0) first_bad = k;
                end
                if (cur_done === 1'b1) begin
                    done_cnt++;
                    done_at = k;
                end
                if (cur_ready !== 1'b0) ready_hi++;
                if ((k - 1) % bc == bc / 2) begin
                    samp[ns] = cur_line;
                    ns++;
                end
            end else begin
                check("ready_after_word", {31'd0, cur_ready}, 32'd1);
                check("idle_line_after_word", {31'd0, cur_line}, 32'd1);
                check("done_low_after_word", {31'd0, cur_done}, 32'd0);
            end
        end
        if (mism != 0) $display("  first bad line cycle n+%0d for word %h", first_bad, w);
        check("line_waveform_mismatches", mism, 0);
        check("done_pulse_count", done_cnt, 1);
        check("done_cycle", done_at, nclk);
        check("ready_low_during_word", ready_hi, 0);
        rx = '0;
        framing_ok = 1'b1;
        for (int f = 0; f < 2; f++) begin
            if (samp[f * 10] !== 1'b0 || samp[f * 10 + 9] !== 1'b1) framing_ok = 1'b0;
            for (int b = 0; b < 8; b++) rx[f * 8 + b] = samp[f * 10 + b + 1];
        end
        check("rx_framing", {31'd0, framing_ok}, 32'd1);
        check("rx_word", {16'd0, rx}, {16'd0, exp_word});
    endtask

    initial begin
        logic [15:0] w;
        int          h;
        valid = 1'b0;
        data  = '0;
        sel   = 1'b0;
        rst   = 1'b0;
        #1 rst = 1'b1;
        #200;
        check("reset_line0", {31'd0, line0}, 32'd1);
        check("reset_ready0", {31'd0, ready0}, 32'd1);
        check("reset_done0", {31'd0, done0}, 32'd0);
        check("reset_line1", {31'd0, line1}, 32'd1);
        check("reset_ready1", {31'd0, ready1}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        tbl[0] = '{word: 16'hA53C, hold: 0,      hold_data: 16'h0000, exp_word: 16'hA53C};
        tbl[1] = '{word: 16'h1234, hold: 0,      hold_data: 16'h0000, exp_word: 16'h1234};
        tbl[2] = '{word: 16'h00FF, hold: 3000,   hold_data: 16'hFFFF, exp_word: 16'h00FF};
        tbl[3] = '{word: 16'h0000, hold: W0 + 1, hold_data: 16'hFFFF, exp_word: 16'h0000};
        tbl[4] = '{word: 16'hFFFF, hold: 0,      hold_data: 16'h0000, exp_word: 16'hFFFF};

        for (int i = 0; i < 5; i++) begin
            if (i == 0 || tbl[i - 1].hold <= W0) start_word(tbl[i].word);
            run_word(tbl[i].word, BC0, tbl[i].hold, tbl[i].hold_data, tbl[i].exp_word);
        end

        // Mid-frame reset while a data bit of 0 is on the line.
        start_word(16'h0000);
        @(negedge clk);
        valid = 1'b0;
        repeat (2999) @(negedge clk);
        check("line_before_reset", {31'd0, line0}, 32'd0);
        rst = 1'b1;
        #1;
        check("reset_mid_line", {31'd0, line0}, 32'd1);
        check("reset_mid_ready", {31'd0, ready0}, 32'd1);
        check("reset_mid_done", {31'd0, done0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start_word(16'h5555);
        run_word(16'h5555, BC0, 0, 16'h0000, 16'h5555);

        sel = 1'b1;
        start_word(16'h8001);
        run_word(16'h8001, BC1, 0, 16'h0000, 16'h8001);
        for (int i = 0; i < 20; i++) begin
            w = 16'($urandom);
            h = $urandom_range(0, W1 - 20);
            start_word(w);
            run_word(w, BC1, h, 16'($urandom), w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_baudrate.md
Name: tx_baudrate

Overview:
UART transmitter with an integrated baud-tick generator, the serial source counterpart of rx_baudrate.
- Accepts one NB_DATA-bit word per handshake.
- Serialises the word as two 8N1 frames, low byte first, onto a single line that feeds rx_baudrate's i_data.
- Sits at the output of the processor/datapath inside top_con_tx; line and tick timing match rx_baudrate bit-for-bit so the pair loops back directly.

Parameters:
NB_DATA, 16, width of the parallel word; must be a multiple of NB_BYTE
NB_BYTE, 8, data bits per UART frame
CLK_FREQ, 5000000, i_clk frequency in Hz
BAUD_RATE, 9600, line bit rate
N_SAMPLES, 16, baud ticks per bit (oversampling factor shared with rx_baudrate)

Ports:
i_clk  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_data  input  NB_DATA  word to transmit, sampled only on acceptance
i_valid  input  1  word available
o_ready  output  1  high only in IDLE; acceptance = i_valid & o_ready
o_data  output  1  serial line, idle high
o_done  output  1  one-cycle pulse when the last stop bit of the word completes

Behaviour:
- Reset (async, active-high): o_data=1, o_ready=1, o_done=0, state=IDLE, all counters and the shift register cleared; applies immediately, including mid-frame.
- Tick divisor DIV = CLK_FREQ/(BAUD_RATE*N_SAMPLES), integer truncation (default 32).
  - One tick every DIV clocks; one bit = N_SAMPLES ticks = BIT_CLKS clocks (default 512).
  - The divider and tick counter are cleared on acceptance, so timing is deterministic relative to the accept edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_data=1. On acceptance (cycle n), latch i_data into the shift register, byte_idx=0, go to START.
  - START: o_data=0 from cycle n+1 for exactly BIT_CLKS clocks, then go to DATA.
  - DATA: drive the LSB of the current byte; shift right after each BIT_CLKS; after NB_BYTE bits go to STOP.
  - STOP: o_data=1 for BIT_CLKS clocks. At the end:
    - if byte_idx < NB_DATA/NB_BYTE-1: increment byte_idx and go to START (no idle gap between frames);
    - else pulse o_done for one cycle and go to IDLE.
- Word duration: (NB_DATA/NB_BYTE)*(NB_BYTE+2)*BIT_CLKS clocks; default 10240. o_done is asserted on cycle n+10240.
- o_ready rises on cycle n+10241, the cycle after o_done.
- A back-to-back word with i_valid held high is accepted on that cycle; its start bit begins on n+10242.
- i_valid while not ready: ignored, no queuing. i_data changes after acceptance have no effect.
- o_data is registered (glitch-free). Unreachable state encodings recover to IDLE with o_data=1.

Decomposition:
- Package uart_pkg holds:
  - state encoding localparams (IDLE/START/DATA/STOP, 2 bits);
  - N_SAMPLES default;
  - NB_BYTE;
  - a DIV calculation function shared with rx_baudrate.
- Sub-module baud_tick_gen (params CLK_FREQ, BAUD_RATE, N_SAMPLES; ports i_clk, i_reset, i_clear, o_tick), reused by rx_baudrate.
- FSM, bit counter, byte index and shift register stay in tx_baudrate.

Test Plan:
1. Reset high 200 ns, then i_data=16'hA53C with i_valid for 1 cycle → o_data low at n+1.
   - Frame 1 bits, LSB first: 0,0,1,1,1,1,0,0, then stop=1.
   - Frame 2: start=0, bits 1,0,1,0,0,1,0,1, stop=1.
   - Each bit 512 clocks; o_done=1 only at n+10240; o_ready=1 at n+10241.
2. Loopback into rx_baudrate with i_data=16'h1234 → rx o_valid pulses once and rx o_data=16'h1234 after the second stop bit.
3. Accept 16'h00FF, then hold i_valid=1 with i_data=16'hFFFF for 3000 cycles mid-word → transmitted word remains 16'h00FF; o_ready stays 0 until n+10241.
4. Assert i_reset at clock n+3000 (DATA state, frame 1) → o_data=1 and o_ready=1 in the same cycle; after release, 16'h5555 transmits correctly from scratch.
5. i_valid held high with alternating words 16'h0000 and 16'hFFFF → consecutive words with exactly one idle-high cycle between the word-1 stop bit and the word-2 start; both patterns intact.
6. Instantiate with CLK_FREQ=1600000, BAUD_RATE=100000 (DIV=1, BIT_CLKS=16), send 16'h8001 → every bit lasts 16 clocks; o_done at n+320.
